// File: rtl/mem_access_unit_if.sv
// CPU-side request/response and DataMemory bus signals of the load/store sequencer.
// slave: the sequencer itself; master: the CPU datapath plus DataMemory.
interface mem_access_unit_if;
    logic        req;
    logic        write;
    logic        is_byte;
    logic        is_unsigned;
    logic [15:0] address;
    logic [15:0] store_data;
    logic        ready;
    logic        done;
    logic        fault;
    logic [15:0] load_data;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_read_data;

    modport slave (
        input  req, write, is_byte, is_unsigned, address, store_data, mem_read_data,
        output ready, done, fault, load_data, mem_address, mem_write_data, mem_write, mem_read
    );

    modport master (
        output req, write, is_byte, is_unsigned, address, store_data, mem_read_data,
        input  ready, done, fault, load_data, mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a big-endian, byte-addressed DataMemory that
// always reads and writes two bytes. Byte stores are read-modify-write.
//
// state  | meaning
// IDLE   | ready, waiting for a request
// ACCESS | one memory read or write at the registered address
// MERGE  | byte store: write back the captured word with one lane replaced
// RESP   | Done pulse, Fault valid
module mem_access_unit #(
    parameter int MEM_BYTES = 128
) (
    input logic              i_clk,
    input logic              i_rst,
    mem_access_unit_if.slave io_bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_MERGE, ST_RESP} state_t;

    localparam logic [15:0] LP_WORD_MAX = 16'(MEM_BYTES - 2);
    localparam logic [15:0] LP_BYTE_MAX = 16'(MEM_BYTES - 1);

    state_t      r_state;
    logic        r_write;
    logic        r_byte;
    logic        r_unsigned;
    logic        r_lane_lo;
    logic [7:0]  r_store_byte;
    logic [15:0] r_merge;
    logic        r_done;
    logic        r_fault;
    logic [15:0] r_load_data;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_fault;
    logic        w_lane_lo;
    logic [15:0] w_base;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_load_ext;
    logic [15:0] w_merged;

    // Accept-time range check and byte lane selection; load extension and store merge.
    always_comb begin
        w_lane_lo   = io_bus.is_byte && (io_bus.address == LP_BYTE_MAX);
        w_fault     = io_bus.is_byte ? (io_bus.address > LP_BYTE_MAX)
                                     : (io_bus.address > LP_WORD_MAX);
        w_base      = w_lane_lo ? (io_bus.address - 16'd1) : io_bus.address;
        w_lane_byte = r_lane_lo ? io_bus.mem_read_data[7:0] : io_bus.mem_read_data[15:8];
        w_load_ext  = r_unsigned ? {8'h00, w_lane_byte} : {{8{w_lane_byte[7]}}, w_lane_byte};
        w_merged    = r_lane_lo ? {r_merge[15:8], r_store_byte} : {r_store_byte, r_merge[7:0]};
    end

    // Sequencer FSM with registered bus strobes and response flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_unsigned   <= 1'b0;
            r_lane_lo    <= 1'b0;
            r_store_byte <= 8'h00;
            r_merge      <= 16'h0000;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_load_data  <= 16'h0000;
            r_mem_addr   <= 16'h0000;
            r_mem_wdata  <= 16'h0000;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.req) begin
                        r_write      <= io_bus.write;
                        r_byte       <= io_bus.is_byte;
                        r_unsigned   <= io_bus.is_unsigned;
                        r_lane_lo    <= w_lane_lo;
                        r_store_byte <= io_bus.store_data[7:0];
                        r_fault      <= w_fault;
                        if (w_fault) begin
                            r_done  <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_mem_addr  <= w_base;
                            r_mem_read  <= !io_bus.write || io_bus.is_byte;
                            r_mem_write <= io_bus.write && !io_bus.is_byte;
                            r_mem_wdata <= (io_bus.write && !io_bus.is_byte) ? io_bus.store_data
                                                                             : 16'h0000;
                            r_state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_write && r_byte) begin
                        r_merge     <= io_bus.mem_read_data;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b1;
                        r_state     <= ST_MERGE;
                    end else begin
                        if (!r_write) begin
                            r_load_data <= r_byte ? w_load_ext : io_bus.mem_read_data;
                        end
                        r_mem_addr  <= 16'h0000;
                        r_mem_wdata <= 16'h0000;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_MERGE: begin
                    r_mem_addr  <= 16'h0000;
                    r_mem_wdata <= 16'h0000;
                    r_mem_write <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= ST_RESP;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by reset so a pending write never lands in a reset cycle.
    assign io_bus.ready          = (r_state == ST_IDLE) && !i_rst;
    assign io_bus.done           = r_done;
    assign io_bus.fault          = r_fault;
    assign io_bus.load_data      = r_load_data;
    assign io_bus.mem_address    = r_mem_addr;
    assign io_bus.mem_write_data = (r_state == ST_MERGE) ? w_merged : r_mem_wdata;
    assign io_bus.mem_write      = r_mem_write && !i_rst;
    assign io_bus.mem_read       = r_mem_read && !i_rst;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: DataMemory model on the bus, byte-level reference
// memory plus expected LoadData computed from the load/store rules.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_BYTES(128)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus.slave)
    );

    // DataMemory model: combinational two-byte read, two-byte write on posedge.
    logic [7:0] tb_mem [128];
    logic       poke_en = 1'b0;
    logic [6:0] poke_addr = 7'd0;
    logic [7:0] poke_data = 8'h00;
    logic [6:0] w_a0, w_a1;
    assign w_a0 = bus.mem_address[6:0];
    assign w_a1 = w_a0 + 7'd1;
    assign bus.mem_read_data = {tb_mem[w_a0], tb_mem[w_a1]};

    initial for (int i = 0; i < 128; i++) tb_mem[i] = 8'h00;

    always @(posedge clk) begin
        if (bus.mem_write) begin
            tb_mem[w_a0] <= bus.mem_write_data[15:8];
            tb_mem[w_a1] <= bus.mem_write_data[7:0];
        end
        if (poke_en) tb_mem[poke_addr] <= poke_data;
    end

    // Reference state.
    logic [7:0]  ref_mem [128];
    logic [15:0] exp_ld = 16'h0000;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = 7'(a); poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic drive(input logic w, b, u, input logic [15:0] a, sd);
        bus.req = 1'b1; bus.write = w; bus.is_byte = b;
        bus.is_unsigned = u; bus.address = a; bus.store_data = sd;
    endtask

    // Issue one request and check its response against the reference.
    task automatic do_op(input logic w, b, u, input logic [15:0] a, sd);
        int  cyc, lat;
        bit  got, saw_rd, saw_wr, have_addr, flt;
        logic [15:0] acc_addr;
        cyc = 0;
        @(negedge clk);
        while (!bus.ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("ready_before_req", bus.ready, 1);
        drive(w, b, u, a, sd);
        @(posedge clk); #1;
        bus.req = 1'b0;

        flt = b ? (a > 16'd127) : (a > 16'd126);
        lat = flt ? 1 : ((w && b) ? 3 : 2);
        if (!flt) begin
            if (!w && !b) exp_ld = {ref_mem[a], ref_mem[a + 1]};
            else if (!w) exp_ld = u ? {8'h00, ref_mem[a]} : {{8{ref_mem[a][7]}}, ref_mem[a]};
            else if (!b) begin ref_mem[a] = sd[15:8]; ref_mem[a + 1] = sd[7:0]; end
            else ref_mem[a] = sd[7:0];
        end

        got = 0; saw_rd = 0; saw_wr = 0; have_addr = 0; acc_addr = 16'h0;
        for (cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (bus.mem_read) saw_rd = 1;
            if (bus.mem_write) saw_wr = 1;
            if ((bus.mem_read || bus.mem_write) && !have_addr) begin
                have_addr = 1; acc_addr = bus.mem_address;
            end
            if (bus.done) begin got = 1; break; end
        end
        chk("done_seen", 32'(got), 1);
        chk("latency", cyc, lat);
        chk("fault", bus.fault, 32'(flt));
        chk("load_data", bus.load_data, exp_ld);
        chk("saw_mem_read", 32'(saw_rd), 32'(!flt && (!w || b)));
        chk("saw_mem_write", 32'(saw_wr), 32'(!flt && w));
        if (!flt) chk("access_addr", acc_addr, (b && a == 16'd127) ? 16'd126 : a);
    endtask

    initial begin
        int c, bad;
        logic [15:0] ra, rsd;
        logic rw, rb, ru;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        drive(0, 0, 0, 16'h0, 16'h0);
        bus.req = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", bus.ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_load_data", bus.load_data, 0);
        chk("rst_mem_strobes", {bus.mem_read, bus.mem_write}, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_mem_wdata", bus.mem_write_data, 0);

        poke(16'h10, 8'hAB); poke(16'h11, 8'hCD); poke(16'h12, 8'h5A);
        do_op(0, 0, 0, 16'h0010, 16'h0);
        chk("word_load_abcd", bus.load_data, 16'hABCD);
        do_op(1, 1, 0, 16'h0011, 16'h0077);
        @(negedge clk);
        chk("bst_mem10", tb_mem[16'h10], 8'hAB);
        chk("bst_mem11", tb_mem[16'h11], 8'h77);
        chk("bst_mem12", tb_mem[16'h12], 8'h5A);

        poke(16'h7E, 8'h12); poke(16'h7F, 8'h80);
        do_op(0, 1, 0, 16'h007F, 16'h0);
        chk("top_signed", bus.load_data, 16'hFF80);
        do_op(0, 1, 1, 16'h007F, 16'h0);
        chk("top_unsigned", bus.load_data, 16'h0080);
        do_op(1, 1, 0, 16'h007F, 16'h0034);
        @(negedge clk);
        chk("top_mem7e", tb_mem[16'h7E], 8'h12);
        chk("top_mem7f", tb_mem[16'h7F], 8'h34);

        do_op(0, 0, 0, 16'h007F, 16'h0);
        do_op(0, 1, 0, 16'h0080, 16'h0);
        chk("fault_ld_kept", bus.load_data, 16'h0080);

        // Reset during the MERGE cycle of a byte store.
        @(negedge clk);
        drive(1, 1, 0, 16'h0010, 16'h00EE);
        @(posedge clk); #1 bus.req = 1'b0;
        @(negedge clk);
        chk("rm_access_read", bus.mem_read, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rm_no_write", bus.mem_write, 0);
        chk("rm_no_done", bus.done, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rm_ready_after", bus.ready, 1);
        bad = 0;
        repeat (4) begin
            if (bus.done) bad++;
            @(negedge clk);
        end
        chk("rm_done_never", bad, 0);
        chk("rm_mem10", tb_mem[16'h10], ref_mem[16'h10]);

        // Req held high across two word loads.
        drive(0, 0, 0, 16'h0010, 16'h0);
        @(negedge clk);
        chk("hold_c1_ready", bus.ready, 0);
        chk("hold_c1_read", bus.mem_read, 1);
        bus.address = 16'h007E;
        @(negedge clk);
        chk("hold_c2_ready", bus.ready, 0);
        chk("hold_c2_done", bus.done, 1);
        chk("hold_ld1", bus.load_data, {ref_mem[16'h10], ref_mem[16'h11]});
        @(negedge clk);
        chk("hold_c3_ready", bus.ready, 1);
        chk("hold_c3_idle", bus.mem_read, 0);
        @(negedge clk);
        chk("hold_c4_read", bus.mem_read, 1);
        chk("hold_c4_addr", bus.mem_address, 16'h007E);
        bus.req = 1'b0;
        @(negedge clk);
        chk("hold_c5_done", bus.done, 1);
        chk("hold_ld2", bus.load_data, {ref_mem[16'h7E], ref_mem[16'h7F]});
        exp_ld = {ref_mem[16'h7E], ref_mem[16'h7F]};

        // Randomized mix of loads, stores and out-of-range requests.
        for (int n = 0; n < 150; n++) begin
            c = $urandom_range(0, 9);
            if (c == 0) ra = 16'($urandom_range(120, 140));
            else if (c == 1) ra = 16'($urandom);
            else ra = 16'($urandom_range(0, 127));
            rw = 1'($urandom); rb = 1'($urandom); ru = 1'($urandom);
            rsd = 16'($urandom);
            do_op(rw, rb, ru, ra, rsd);
        end

        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 128; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk("final_mem_diffs", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the CPU datapath and the 128-byte, big-endian, byte-addressed DataMemory. Accepts one word or byte request at a time, range-checks the address, and drives DataMemory's Address/WriteData/MemWrite/MemRead. Byte stores are done as read-modify-write, because DataMemory always writes two bytes. Returns registered load data with sign or zero extension, plus a one-cycle Done/Fault response.

## Interface
- MEM_BYTES, 128: data memory size in bytes; the legal address range is 0..MEM_BYTES-1.
- Clock  in  1  single clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  request strobe; sampled only when Ready=1.
- Write  in  1  1 = store, 0 = load.
- Byte  in  1  1 = byte access, 0 = 16-bit word access.
- Unsigned  in  1  byte loads only: 1 = zero-extend, 0 = sign-extend.
- Address  in  16  byte address.
- StoreData  in  16  word store uses [15:0]; byte store uses [7:0].
- Ready  out  1  idle, can accept a request.
- Done  out  1  one-cycle completion pulse.
- Fault  out  1  valid with Done; 1 = out-of-range, no memory access made.
- LoadData  out  16  load result; held until the next load completes.
- MemAddress  out  16  to DataMemory Address.
- MemWriteData  out  16  to DataMemory WriteData.
- MemWrite  out  1  to DataMemory MemWrite.
- MemRead  out  1  to DataMemory MemRead.
- MemReadData  in  16  from DataMemory ReadData (combinational: {mem[A], mem[A+1]}).

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- Ready = (state==IDLE) && !Reset.
- **Accept:** a request is accepted at the posedge where Req && Ready.
  - Write, Byte, Unsigned, Address and StoreData are registered at accept.
  - Inputs are ignored at all other times; there is no queuing.
- **Range check at accept:**
  - Word access faults if Address > MEM_BYTES-2.
  - Byte access faults if Address > MEM_BYTES-1.
  - A faulting request goes IDLE->RESP with Fault=1. It never asserts MemRead or MemWrite, and LoadData is unchanged.
- **Byte base/lane:**
  - If Address == MEM_BYTES-1: base = Address-1, lane = low byte.
  - Otherwise: base = Address, lane = high byte.
  - This keeps every memory access within range.
- **ACCESS** (one cycle): MemAddress = Address for word access, base for byte access.
  - Word load: MemRead=1; LoadData <= MemReadData. Next state RESP.
  - Word store: MemWrite=1, MemWriteData=StoreData. Next state RESP.
  - Byte load: MemRead=1; the lane byte is extended per Unsigned into LoadData. Next state RESP.
  - Byte store: MemRead=1; the word is captured into a merge register. Next state MERGE.
- **MERGE** (byte store only): MemAddress = base, MemWrite=1.
  - MemWriteData = captured word with the lane byte replaced by StoreData[7:0]; the other byte is written back unchanged.
  - Next state RESP.
- **RESP:** Done=1 and Fault as determined at accept. Next state IDLE.
- **Idle bus values:** when neither MemRead nor MemWrite is asserted, MemAddress and MemWriteData are 0.
- **Reset:**
  - MemWrite and MemRead are combinationally forced to 0 while Reset=1, so no write occurs in the reset cycle even mid-operation.
  - At the next posedge the state is IDLE and any in-flight request is dropped with no Done.

## Timing
- **Reset values:** state IDLE; Done 0, Fault 0, LoadData 0, MemWrite 0, MemRead 0, MemAddress 0, MemWriteData 0, merge register 0.
- **Cycle numbering:** C0 = the cycle in which the request is accepted at its closing posedge.
- Word load/store, byte load: ACCESS in C1, Done in C2, Ready again in C3.
- Byte store: ACCESS C1, MERGE C2, Done C3, Ready C4.
- Fault: Done+Fault in C1, Ready in C2.
- **When results appear:**
  - The DataMemory write commits at the posedge ending the MemWrite cycle.
  - LoadData is valid in the Done cycle.
- **Back-to-back:** maximum throughput is one request per 3 cycles (word or byte load), per 4 cycles (byte store), or per 2 cycles (fault).
- All outputs are driven combinationally from state and registers; there are no combinational paths from Req or Address.

## Test plan
- **Word load:** preload mem[0x10]=0xAB, mem[0x11]=0xCD; load word at 0x0010 -> MemRead in C1, Done in C2, LoadData=0xABCD, Fault=0.
- **Byte store:** same preload, mem[0x12]=0x5A; byte store 0x0077 at 0x0011 -> C1 read at 0x0011, C2 write 0xCD->0x77 at 0x0011 with low byte 0x5A written back -> mem[0x10..0x12]=AB 77 5A; Done in C3.
- **Top byte:** mem[0x7E]=0x12, mem[0x7F]=0x80. Signed byte load at 0x007F -> MemAddress=0x007E, LoadData=0xFF80. Unsigned -> 0x0080. Byte store 0x0034 at 0x007F -> mem[0x7E..0x7F]=12 34.
- **Range faults:** word load at 0x007F and byte load at 0x0080 -> Done+Fault in C1, MemRead/MemWrite never high, LoadData unchanged.
- **Reset mid-op:** Reset=1 during the MERGE cycle of a byte store to 0x0010 -> MemWrite stays 0, memory unchanged, no Done, Ready=1 the cycle after Reset drops.
- **Held Req:** hold Req=1 across two word loads -> second accept occurs in C3 of the first, never while Ready=0; both LoadData values correct.
